// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: cache-line fill controller between a cache and pipelined memory.
// On a miss it issues one read per word of the line (optionally critical-word-first,
// wrapping inside the line), writes each returned word into the data array, then
// pulses a single tag-array write to close the fill.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   miss_detected      miss request, sampled only while idle
//   miss_address       byte address of the missing access, captured with the miss
//   fsm_busy           high while a fill is in progress (REQ, WAIT, DONE)
//   memory_read        one read request per high cycle
//   memory_address     byte address of the word being requested
//   memory_data_valid  one returned word this cycle (in request order)
//   memory_data        returned word
//   write_data_array   write cache_word_data into the data array this cycle
//   cache_word_addr    byte address of the word written; block base on tag write
//   cache_word_data    returned word, passed straight through
//   write_tag_array    one-cycle pulse marking fill completion
module cache_fill_fsm #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int BLOCK_WORDS = 8,
  parameter int CRIT_FIRST  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_detected,
  input  logic [ADDR_WIDTH-1:0] miss_address,
  output logic                  fsm_busy,
  output logic                  memory_read,
  output logic [ADDR_WIDTH-1:0] memory_address,
  input  logic                  memory_data_valid,
  input  logic [DATA_WIDTH-1:0] memory_data,
  output logic                  write_data_array,
  output logic [ADDR_WIDTH-1:0] cache_word_addr,
  output logic [DATA_WIDTH-1:0] cache_word_data,
  output logic                  write_tag_array
);

  localparam int BYTES    = DATA_WIDTH / 8;
  localparam int BSHIFT   = $clog2(BYTES);
  localparam int IW       = $clog2(BLOCK_WORDS);
  localparam int OFF_BITS = IW + BSHIFT;
  localparam int CW       = IW + 1;

  localparam logic [CW-1:0] BW_CNT   = CW'(BLOCK_WORDS);
  localparam logic [CW-1:0] LAST_CNT = CW'(BLOCK_WORDS - 1);

  localparam logic [ADDR_WIDTH-1:0] BASE_MASK =
    {{(ADDR_WIDTH - OFF_BITS){1'b1}}, {OFF_BITS{1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [CW-1:0]         issue_cnt;
  logic [CW-1:0]         issue_nx;
  logic [CW-1:0]         recv_cnt;
  logic [CW-1:0]         recv_nx;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] base_nx;
  logic [IW-1:0]         start_q;
  logic [IW-1:0]         start_nx;

  logic recv_ok;
  logic last_recv;
  logic last_issue;

  // The word index is kept IW bits wide, so the wrap is a natural
  // modulo-BLOCK_WORDS and is OR-ed into the cleared offset field:
  // it can never carry into the tag bits.
  function automatic logic [ADDR_WIDTH-1:0] word_addr(
    input logic [ADDR_WIDTH-1:0] base,
    input logic [IW-1:0]         start,
    input logic [CW-1:0]         cnt
  );
    logic [IW-1:0]         idx;
    logic [ADDR_WIDTH-1:0] off;
    idx = start + cnt[IW-1:0];
    off = '0;
    off[OFF_BITS-1:BSHIFT] = idx;
    return base | off;
  endfunction

  assign fsm_busy        = (state != IDLE);
  assign cache_word_data = memory_data;

  // Returns are accepted only while a fill is collecting words and
  // the line is not yet full; anything else is a stray strobe.
  assign recv_ok = ((state == REQ) || (state == WAIT)) &&
                   memory_data_valid &&
                   (recv_cnt != BW_CNT);

  assign last_recv  = recv_ok && (recv_cnt == LAST_CNT);
  assign last_issue = (issue_cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      base_q    <= '0;
      start_q   <= '0;
    end else begin
      state     <= state_nx;
      issue_cnt <= issue_nx;
      recv_cnt  <= recv_nx;
      base_q    <= base_nx;
      start_q   <= start_nx;
    end
  end

  always_comb begin
    state_nx         = state;
    issue_nx         = issue_cnt;
    recv_nx          = recv_cnt;
    base_nx          = base_q;
    start_nx         = start_q;
    memory_read      = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    cache_word_addr  = '0;
    write_tag_array  = 1'b0;

    // Receive path runs alongside issue so short latencies overlap.
    if (recv_ok) begin
      write_data_array = 1'b1;
      cache_word_addr  = word_addr(base_q, start_q, recv_cnt);
      recv_nx          = recv_cnt + 1'b1;
    end

    unique case (state)
      IDLE: begin
        if (miss_detected) begin
          base_nx  = miss_address & BASE_MASK;
          start_nx = (CRIT_FIRST != 0) ?
                     IW'(miss_address >> BSHIFT) : '0;
          issue_nx = '0;
          recv_nx  = '0;
          state_nx = REQ;
        end
      end
      REQ: begin
        memory_read    = 1'b1;
        memory_address = word_addr(base_q, start_q, issue_cnt);
        issue_nx       = issue_cnt + 1'b1;
        if (last_issue) begin
          // Zero-latency memory can finish the line in the same cycle.
          state_nx = last_recv ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (last_recv) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        write_tag_array = 1'b1;
        cache_word_addr = base_q;
        state_nx        = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule
